// File: rtl/ngs_pkg.sv
// Shared types, register-map constants and helpers for the NGS DAC/volume/mix stage.
package ngs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_SAT  = 2'd2
  } state_e;

  localparam int VOL_BASE         = 0;
  localparam int PAN_L_BIT        = 0;
  localparam int PAN_R_BIT        = 1;
  localparam int CTRL_MUTE_BIT    = 0;
  localparam int CTRL_CLR_OVR_BIT = 7;

  function automatic int pan_base(input int nch);
    return nch;
  endfunction

  function automatic int ctrl_addr(input int nch);
    return 2 * nch;
  endfunction

  // Lower half of the channels sits on the left, upper half on the right.
  function automatic logic [1:0] default_pan(input int ch, input int nch);
    return (ch < nch / 2) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic signed [31:0] saturate(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/ngs_mac_unit.sv
// One signed sample*volume multiplier feeding the left/right mix accumulators.
module ngs_mac_unit
  import ngs_pkg::*;
#(
  parameter int VOL_W = 6,
  parameter int ACC_W = 18
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [7:0]       smp_i,
  input  logic [VOL_W-1:0]        vol_i,
  input  logic [1:0]              pan_i,
  output logic signed [ACC_W-1:0] acc_l_o,
  output logic signed [ACC_W-1:0] acc_r_o
);

  localparam int PW = VOL_W + 9;

  logic signed [PW-1:0]    smp_ext;
  logic signed [PW-1:0]    vol_ext;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_l_q, acc_l_d;
  logic signed [ACC_W-1:0] acc_r_q, acc_r_d;

  always_comb begin
    smp_ext  = PW'(smp_i);
    vol_ext  = PW'($signed({1'b0, vol_i}));
    prod     = smp_ext * vol_ext;
    prod_ext = ACC_W'(prod);
    acc_l_d  = acc_l_q;
    acc_r_d  = acc_r_q;
    if (clr_i) begin
      acc_l_d = '0;
      acc_r_d = '0;
    end else if (en_i) begin
      if (pan_i[PAN_L_BIT]) acc_l_d = acc_l_q + prod_ext;
      if (pan_i[PAN_R_BIT]) acc_r_d = acc_r_q + prod_ext;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_l_q <= '0;
      acc_r_q <= '0;
    end else begin
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
    end
  end

  assign acc_l_o = acc_l_q;
  assign acc_r_o = acc_r_q;

endmodule

// File: rtl/ngs_dac_mixer.sv
// NGS sound-card mixer: register file, sample capture, frame FSM (IDLE/MAC/SAT) and
// saturated stereo output. TICK is a strobe with no back-pressure; ticks arriving while
// busy are queued one deep, further ones are dropped and flagged in OVERRUN.
module ngs_dac_mixer
  import ngs_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int VOL_W = 6,
  parameter int OUT_W = 16
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      TICK,
  input  logic                      REG_WR,
  input  logic [$clog2(NCH)+1:0]    REG_ADDR,
  input  logic [7:0]                REG_DI,
  input  logic                      SMP_WR,
  input  logic [$clog2(NCH)-1:0]    SMP_CH,
  input  logic [7:0]                SMP_DI,
  output logic signed [OUT_W-1:0]   OUTL,
  output logic signed [OUT_W-1:0]   OUTR,
  output logic                      OUT_VALID,
  output logic                      BUSY,
  output logic                      OVERRUN,
  output state_e                    DBG_STATE
);

  localparam int CW    = $clog2(NCH);
  localparam int AW    = CW + 2;
  localparam int ACC_W = VOL_W + 9 + CW;
  localparam logic [AW-1:0] PAN_A  = AW'(pan_base(NCH));
  localparam logic [AW-1:0] CTRL_A = AW'(ctrl_addr(NCH));
  localparam logic [CW-1:0] K_LAST = CW'(NCH - 1);

  logic signed [7:0]  smp_q    [NCH];
  logic [VOL_W-1:0]   vol_q    [NCH];
  logic [1:0]         pan_q    [NCH];
  logic signed [7:0]  sh_smp_q [NCH];
  logic [VOL_W-1:0]   sh_vol_q [NCH];
  logic [1:0]         sh_pan_q [NCH];

  state_e             state_q, state_d;
  logic [CW-1:0]      k_q, k_d;
  logic               pend_q, pend_d;
  logic               ovr_q, ovr_d;
  logic               mute_q;
  logic signed [OUT_W-1:0] outl_q, outr_q, outl_d, outr_d;
  logic               ovalid_q;
  logic               start, mac_en, ctrl_wr;
  logic [CW-1:0]      reg_idx;
  logic signed [ACC_W-1:0] acc_l, acc_r;
  logic signed [31:0] sat_l, sat_r;

  assign reg_idx = REG_ADDR[CW-1:0];
  assign ctrl_wr = REG_WR && (REG_ADDR == CTRL_A);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    start   = 1'b0;
    mac_en  = 1'b0;
    if (ctrl_wr && REG_DI[CTRL_CLR_OVR_BIT]) ovr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (TICK || pend_q) begin
          start   = 1'b1;
          state_d = ST_MAC;
          k_d     = '0;
          // A fresh tick arriving together with a pending one re-queues itself.
          pend_d  = pend_q && TICK;
        end
      end
      ST_MAC: begin
        mac_en = 1'b1;
        k_d    = k_q + 1'b1;
        if (k_q == K_LAST) state_d = ST_SAT;
      end
      ST_SAT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Applied after the clear so that a dropped tick wins over a same-cycle clear.
    if (state_q != ST_IDLE && TICK) begin
      if (pend_q) ovr_d = 1'b1;
      else        pend_d = 1'b1;
    end
  end

  always_comb begin
    sat_l  = saturate(32'(acc_l), OUT_W);
    sat_r  = saturate(32'(acc_r), OUT_W);
    outl_d = outl_q;
    outr_d = outr_q;
    if (state_q == ST_SAT) begin
      outl_d = mute_q ? '0 : sat_l[OUT_W-1:0];
      outr_d = mute_q ? '0 : sat_r[OUT_W-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      mute_q   <= 1'b0;
      outl_q   <= '0;
      outr_q   <= '0;
      ovalid_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        smp_q[i]    <= '0;
        vol_q[i]    <= '0;
        pan_q[i]    <= default_pan(i, NCH);
        sh_smp_q[i] <= '0;
        sh_vol_q[i] <= '0;
        sh_pan_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      outl_q   <= outl_d;
      outr_q   <= outr_d;
      ovalid_q <= (state_q == ST_SAT);
      if (REG_WR) begin
        if (REG_ADDR < PAN_A)       vol_q[reg_idx] <= REG_DI[VOL_W-1:0];
        else if (REG_ADDR < CTRL_A) pan_q[reg_idx] <= REG_DI[1:0];
        else if (ctrl_wr)           mute_q <= REG_DI[CTRL_MUTE_BIT];
      end
      if (SMP_WR) smp_q[SMP_CH] <= {~SMP_DI[7], SMP_DI[6:0]};
      if (start) begin
        for (int i = 0; i < NCH; i++) begin
          sh_smp_q[i] <= smp_q[i];
          sh_vol_q[i] <= vol_q[i];
          sh_pan_q[i] <= pan_q[i];
        end
      end
    end
  end

  ngs_mac_unit #(
    .VOL_W (VOL_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .CLK     (CLK),
    .RESET   (RESET),
    .clr_i   (start),
    .en_i    (mac_en),
    .smp_i   (sh_smp_q[k_q]),
    .vol_i   (sh_vol_q[k_q]),
    .pan_i   (sh_pan_q[k_q]),
    .acc_l_o (acc_l),
    .acc_r_o (acc_r)
  );

  assign OUTL      = outl_q;
  assign OUTR      = outr_q;
  assign OUT_VALID = ovalid_q;
  assign BUSY      = (state_q != ST_IDLE);
  assign OVERRUN   = ovr_q;
  assign DBG_STATE = state_q;

endmodule
